gcbp_bram_reader: RTL and testbench

- Read side of the GCBP BRAM array.
- On each frame rotation it walks all 16 sub-images, line by line, and fetches the current-frame and previous-frame GCBP line for each.
- Each line pair goes to the downstream motion-matching engine through a valid/ready handshake.
- Works from the frame-location outputs of the GCBP writer: it reads the curr and prev regions while the writer fills the next region.

---
 rtl/gcbp_pkg.sv | 35 +++
 rtl/gcbp_bram_slice_mux.sv | 22 ++
 rtl/gcbp_bram_reader.sv | 137 +++++++++++++
 tb/tb_gcbp_bram_reader.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcbp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gcbp_pkg: shared GCBP BRAM array geometry and address layout.  Rev 1.0
// ---------------------------------------------------------------------------
package gcbp_pkg;

   localparam int C_NUM_BRAMS       = 16;
   localparam int C_LINE_WIDTH      = 128;
   localparam int C_SUBIMAGE_HEIGHT = 64;
   localparam int C_LINE_CNT_BITS   = 6;
   localparam int C_ADDR_WIDTH      = 9;
   localparam int C_SUB_IDX_BITS    = 4;
   localparam int C_LOC_BITS        = 2;

   localparam logic [C_LINE_CNT_BITS-1:0] C_LAST_LINE = C_LINE_CNT_BITS'(C_SUBIMAGE_HEIGHT - 1);
   localparam logic [C_SUB_IDX_BITS-1:0]  C_LAST_SUB  = C_SUB_IDX_BITS'(C_NUM_BRAMS - 1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_CURR  = 3'd1,
      ST_RD_PREV  = 3'd2,
      ST_CAP_PREV = 3'd3,
      ST_OUT      = 3'd4
   } gcbp_rd_state_e;

   // Same word layout the writer uses: one 64-line region per frame location.
   function automatic logic [C_ADDR_WIDTH-1:0] compose_addr(
      input logic [C_LOC_BITS-1:0]      loc,
      input logic [C_LINE_CNT_BITS-1:0] line
   );
      return {1'b0, loc, line};
   endfunction

endpackage
`default_nettype wire

// File: rtl/gcbp_bram_slice_mux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gcbp_bram_slice_mux: picks one BRAM's 128-bit word off the array bus.  Rev 1.0
// ---------------------------------------------------------------------------
module gcbp_bram_slice_mux
   import gcbp_pkg::*;
(
   input  logic [C_NUM_BRAMS*C_LINE_WIDTH-1:0] bram_data_i,
   input  logic [C_SUB_IDX_BITS-1:0]           sel_i,
   output logic [C_LINE_WIDTH-1:0]             slice_o
);

   logic [C_LINE_WIDTH-1:0] w_slices [C_NUM_BRAMS];

   for (genvar k = 0; k < C_NUM_BRAMS; k++) begin : g_slice
      assign w_slices[k] = bram_data_i[k*C_LINE_WIDTH +: C_LINE_WIDTH];
   end

   assign slice_o = w_slices[sel_i];

endmodule
`default_nettype wire

// File: rtl/gcbp_bram_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gcbp_bram_reader: streams curr/prev GCBP line pairs of all sub-images.  Rev 1.0
// ---------------------------------------------------------------------------
module gcbp_bram_reader
   import gcbp_pkg::*;
(
   input  logic                                i_clk,
   input  logic                                i_reset,
   input  logic                                i_start,
   input  logic [C_LOC_BITS-1:0]               i_curr_frame_loc,
   input  logic [C_LOC_BITS-1:0]               i_prev_frame_loc,
   output logic [C_ADDR_WIDTH-1:0]             o_bram_array_read_addr,
   output logic                                o_bram_array_read_enable,
   input  logic [C_NUM_BRAMS*C_LINE_WIDTH-1:0] i_bram_array_read_data,
   output logic [C_LINE_WIDTH-1:0]             o_curr_line,
   output logic [C_LINE_WIDTH-1:0]             o_prev_line,
   output logic [C_SUB_IDX_BITS-1:0]           o_subimage_idx,
   output logic [C_LINE_CNT_BITS-1:0]          o_line_idx,
   output logic                                o_valid,
   input  logic                                i_ready,
   output logic                                o_last,
   output logic                                o_busy,
   output logic                                o_start_error
);

   gcbp_rd_state_e                state_q;
   logic [C_SUB_IDX_BITS-1:0]     sub_q, sub_d;
   logic [C_LINE_CNT_BITS-1:0]    line_q, line_d;
   logic [C_LOC_BITS-1:0]         curr_loc_q, prev_loc_q;
   logic [C_ADDR_WIDTH-1:0]       addr_q;
   logic                          en_q;
   logic [C_LINE_WIDTH-1:0]       curr_line_q, prev_line_q;
   logic                          valid_q, last_q, busy_q, start_err_q;
   logic [C_LINE_WIDTH-1:0]       w_slice;
   logic                          w_final;
   logic                          w_start_ok;

   gcbp_bram_slice_mux u_slice_mux (
      .bram_data_i (i_bram_array_read_data),
      .sel_i       (sub_q),
      .slice_o     (w_slice)
   );

   always_comb begin
      line_d     = line_q + 1'b1;
      sub_d      = (line_q == C_LAST_LINE) ? sub_q + 1'b1 : sub_q;
      w_final    = (line_q == C_LAST_LINE) && (sub_q == C_LAST_SUB);
      w_start_ok = i_start && (i_curr_frame_loc != i_prev_frame_loc);
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= ST_IDLE;
         sub_q       <= '0;
         line_q      <= '0;
         curr_loc_q  <= '0;
         prev_loc_q  <= '0;
         addr_q      <= '0;
         en_q        <= 1'b0;
         curr_line_q <= '0;
         prev_line_q <= '0;
         valid_q     <= 1'b0;
         last_q      <= 1'b0;
         busy_q      <= 1'b0;
         start_err_q <= 1'b0;
      end else begin
         // A start is only taken from IDLE; the final-handshake cycle still counts as busy.
         start_err_q <= i_start && ((state_q != ST_IDLE) || !w_start_ok);
         case (state_q)
            ST_IDLE: begin
               if (w_start_ok) begin
                  curr_loc_q <= i_curr_frame_loc;
                  prev_loc_q <= i_prev_frame_loc;
                  sub_q      <= '0;
                  line_q     <= '0;
                  addr_q     <= compose_addr(i_curr_frame_loc, '0);
                  en_q       <= 1'b1;
                  busy_q     <= 1'b1;
                  state_q    <= ST_RD_CURR;
               end
            end
            ST_RD_CURR: begin
               addr_q  <= compose_addr(prev_loc_q, line_q);
               en_q    <= 1'b1;
               state_q <= ST_RD_PREV;
            end
            ST_RD_PREV: begin
               curr_line_q <= w_slice;
               en_q        <= 1'b0;
               state_q     <= ST_CAP_PREV;
            end
            ST_CAP_PREV: begin
               prev_line_q <= w_slice;
               valid_q     <= 1'b1;
               last_q      <= w_final;
               state_q     <= ST_OUT;
            end
            ST_OUT: begin
               if (i_ready) begin
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
                  if (w_final) begin
                     busy_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end else begin
                     line_q  <= line_d;
                     sub_q   <= sub_d;
                     addr_q  <= compose_addr(curr_loc_q, line_d);
                     en_q    <= 1'b1;
                     state_q <= ST_RD_CURR;
                  end
               end
            end
            default: begin
               en_q    <= 1'b0;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_bram_array_read_addr   = addr_q;
   assign o_bram_array_read_enable = en_q;
   assign o_curr_line              = curr_line_q;
   assign o_prev_line              = prev_line_q;
   assign o_subimage_idx           = sub_q;
   assign o_line_idx               = line_q;
   assign o_valid                  = valid_q;
   assign o_last                   = last_q;
   assign o_busy                   = busy_q;
   assign o_start_error            = start_err_q;

endmodule
`default_nettype wire

// File: tb/tb_gcbp_bram_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_gcbp_bram_reader: directed bench for the GCBP BRAM read pass.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_gcbp_bram_reader;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_start = 1'b0;
   logic [1:0]    i_curr = 2'd0;
   logic [1:0]    i_prev = 2'd0;
   logic [8:0]    rd_addr;
   logic          rd_en;
   logic [2047:0] rdata = '1;
   logic [127:0]  curr_line, prev_line;
   logic [3:0]    sub_idx;
   logic [5:0]    line_idx;
   logic          valid, last, busy, serr;
   logic          ready = 1'b0;

   int            total = 0;
   int            bad = 0;
   logic [8:0]    addrq[$];

   gcbp_bram_reader dut (
      .i_clk                    (clk),
      .i_reset                  (rst),
      .i_start                  (i_start),
      .i_curr_frame_loc         (i_curr),
      .i_prev_frame_loc         (i_prev),
      .o_bram_array_read_addr   (rd_addr),
      .o_bram_array_read_enable (rd_en),
      .i_bram_array_read_data   (rdata),
      .o_curr_line              (curr_line),
      .o_prev_line              (prev_line),
      .o_subimage_idx           (sub_idx),
      .o_line_idx               (line_idx),
      .o_valid                  (valid),
      .i_ready                  (ready),
      .o_last                   (last),
      .o_busy                   (busy),
      .o_start_error            (serr)
   );

   always #5 clk = ~clk;

   // Tag each BRAM word with its address and BRAM number.
   function automatic logic [127:0] bram_word(input logic [8:0] a, input int k);
      logic [3:0] kk;
      kk = k[3:0];
      return {4{7'd0, a, 12'd0, kk}};
   endfunction

   // One-cycle-latency BRAM array; junk when not enabled.
   always @(posedge clk) begin
      if (rd_en) begin
         for (int k = 0; k < 16; k++) rdata[k*128 +: 128] <= bram_word(rd_addr, k);
      end else begin
         rdata <= '1;
      end
   end

   always @(negedge clk) begin
      if (!rst && rd_en) addrq.push_back(rd_addr);
   end

   // Consumes one whole pass, checking every pair, its two reads, and hold behaviour.
   task automatic consume_pass(input logic [1:0] c, input logic [1:0] p, input bit bp,
                               input int start_pair, input int cyc0, output int cycles);
      int pair, cyc, inj;
      bit held;
      logic [127:0] h_c, h_p, e_c, e_p;
      logic [3:0]   h_s, es;
      logic [5:0]   h_l, el;
      logic         h_last, e_last;
      logic [8:0]   ea_c, ea_p, ga, gb;
      pair = 0; cyc = cyc0; inj = 0; held = 0;
      h_c = '0; h_p = '0; h_s = '0; h_l = '0; h_last = 1'b0;
      while (pair < 1024 && cyc < cyc0 + 12000) begin
         @(negedge clk);
         cyc++;
         i_start = 1'b0;
         if (inj == 1) begin
            total++;
            if (serr !== 1'b1 || busy !== 1'b1) begin
               bad++;
               $display("FAIL start_while_busy: err=%b busy=%b, want err=1 busy=1", serr, busy);
            end
            inj = 2;
         end else if (inj == 2) begin
            total++;
            if (serr !== 1'b0) begin
               bad++;
               $display("FAIL start_err_width: err=%b, want 0", serr);
            end
            inj = 3;
         end
         if (held) begin
            total++;
            if (valid !== 1'b1 || curr_line !== h_c || prev_line !== h_p ||
                sub_idx !== h_s || line_idx !== h_l || last !== h_last) begin
               bad++;
               $display("FAIL hold_stable pair %0d: valid=%b sub=%0d line=%0d, want valid=1 sub=%0d line=%0d",
                        pair, valid, sub_idx, line_idx, h_s, h_l);
            end
         end
         held = 1'b0;
         ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         if (valid === 1'b1) begin
            if (pair == start_pair && inj == 0) begin
               i_start = 1'b1;
               i_curr  = p;
               i_prev  = c;
               inj     = 1;
            end
            if (ready) begin
               es     = 4'(pair / 64);
               el     = 6'(pair % 64);
               ea_c   = {1'b0, c, el};
               ea_p   = {1'b0, p, el};
               e_c    = bram_word(ea_c, int'(es));
               e_p    = bram_word(ea_p, int'(es));
               e_last = (pair == 1023);
               total++;
               if (sub_idx !== es || line_idx !== el || curr_line !== e_c ||
                   prev_line !== e_p || last !== e_last) begin
                  bad++;
                  $display("FAIL pair %0d: sub=%0d line=%0d last=%b curr=%h prev=%h, want sub=%0d line=%0d last=%b curr=%h prev=%h",
                           pair, sub_idx, line_idx, last, curr_line[31:0], prev_line[31:0],
                           es, el, e_last, e_c[31:0], e_p[31:0]);
               end
               total++;
               if (addrq.size() < 2) begin
                  bad++;
                  $display("FAIL reads pair %0d: got %0d reads, want 2", pair, addrq.size());
               end else begin
                  ga = addrq.pop_front();
                  gb = addrq.pop_front();
                  if (ga !== ea_c || gb !== ea_p) begin
                     bad++;
                     $display("FAIL read_addr pair %0d: got %h,%h want %h,%h", pair, ga, gb, ea_c, ea_p);
                  end
               end
               pair++;
            end else begin
               held = 1'b1;
               h_c = curr_line; h_p = prev_line; h_s = sub_idx; h_l = line_idx; h_last = last;
            end
         end
      end
      total++;
      if (pair != 1024) begin
         bad++;
         $display("FAIL pass_timeout: pairs=%0d, want 1024", pair);
      end
      cycles = cyc;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      total++;
      if (rd_addr !== 9'd0 || rd_en !== 1'b0 || curr_line !== '0 || prev_line !== '0 ||
          sub_idx !== 4'd0 || line_idx !== 6'd0 || valid !== 1'b0 || last !== 1'b0 ||
          busy !== 1'b0 || serr !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs: addr=%h en=%b valid=%b busy=%b, want all 0", rd_addr, rd_en, valid, busy);
      end
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || rd_en !== 1'b0 || valid !== 1'b0) begin
         bad++;
         $display("FAIL idle_after_reset: busy=%b en=%b valid=%b, want 0", busy, rd_en, valid);
      end
   endtask

   task automatic test_full_pass();
      int cycles;
      addrq.delete();
      i_curr = 2'd1; i_prev = 2'd0; i_start = 1'b1; ready = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      total++;
      if (rd_addr !== 9'h040 || rd_en !== 1'b1 || busy !== 1'b1) begin
         bad++;
         $display("FAIL first_addr: addr=%h en=%b busy=%b, want 040 1 1", rd_addr, rd_en, busy);
      end
      @(negedge clk);
      total++;
      if (rd_addr !== 9'h000 || rd_en !== 1'b1) begin
         bad++;
         $display("FAIL second_addr: addr=%h en=%b, want 000 1", rd_addr, rd_en);
      end
      consume_pass(2'd1, 2'd0, 1'b0, -1, 2, cycles);
      total++;
      if (cycles !== 4096) begin
         bad++;
         $display("FAIL pass_cycles: got %0d, want 4096", cycles);
      end
      // Start coinciding with the final handshake must be refused.
      i_start = 1'b1; i_curr = 2'd3; i_prev = 2'd0;
      @(negedge clk);
      i_start = 1'b0;
      total++;
      if (busy !== 1'b0 || serr !== 1'b1 || rd_en !== 1'b0 || valid !== 1'b0) begin
         bad++;
         $display("FAIL end_of_pass: busy=%b err=%b en=%b valid=%b, want 0 1 0 0", busy, serr, rd_en, valid);
      end
   endtask

   task automatic test_backpressure();
      int cycles;
      addrq.delete();
      i_curr = 2'd0; i_prev = 2'd3; i_start = 1'b1;
      consume_pass(2'd0, 2'd3, 1'b1, -1, 0, cycles);
      @(negedge clk);
      ready = 1'b1;
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL bp_idle: busy=%b, want 0", busy);
      end
   endtask

   task automatic test_equal_locs();
      addrq.delete();
      i_curr = 2'd2; i_prev = 2'd2; i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      total++;
      if (serr !== 1'b1 || busy !== 1'b0 || rd_en !== 1'b0) begin
         bad++;
         $display("FAIL equal_locs: err=%b busy=%b en=%b, want 1 0 0", serr, busy, rd_en);
      end
      @(negedge clk);
      total++;
      if (serr !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0 || addrq.size() != 0) begin
         bad++;
         $display("FAIL equal_locs_after: err=%b busy=%b en=%b reads=%0d, want 0 0 0 0",
                  serr, busy, rd_en, addrq.size());
      end
   endtask

   task automatic test_start_while_busy();
      int cycles;
      addrq.delete();
      i_curr = 2'd3; i_prev = 2'd1; i_start = 1'b1;
      consume_pass(2'd3, 2'd1, 1'b0, 500, 0, cycles);
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      int cycles;
      addrq.delete();
      i_curr = 2'd2; i_prev = 2'd1; i_start = 1'b1; ready = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      // Pair 478 (sub 7, line 30) is in its RD_PREV cycle at cycle 4*478+2.
      repeat (1913) @(negedge clk);
      total++;
      if (sub_idx !== 4'd7 || line_idx !== 6'd30 || rd_en !== 1'b1 || rd_addr !== {1'b0, 2'd1, 6'd30}) begin
         bad++;
         $display("FAIL pre_reset_pos: sub=%0d line=%0d en=%b addr=%h, want 7 30 1 %h",
                  sub_idx, line_idx, rd_en, rd_addr, {1'b0, 2'd1, 6'd30});
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if (rd_addr !== 9'd0 || rd_en !== 1'b0 || curr_line !== '0 || prev_line !== '0 ||
          sub_idx !== 4'd0 || line_idx !== 6'd0 || valid !== 1'b0 || last !== 1'b0 ||
          busy !== 1'b0 || serr !== 1'b0) begin
         bad++;
         $display("FAIL async_reset: addr=%h en=%b sub=%0d line=%0d busy=%b, want all 0",
                  rd_addr, rd_en, sub_idx, line_idx, busy);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      addrq.delete();
      i_curr = 2'd1; i_prev = 2'd2; i_start = 1'b1;
      consume_pass(2'd1, 2'd2, 1'b0, -1, 0, cycles);
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_full_pass();
      test_backpressure();
      test_equal_locs();
      test_start_while_busy();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
